adc_seq: RTL and testbench
==========================

ADC_SEQ -- requirements
Module: adc_seq

Interface
REQ-001 Parameter W, default 5: ADC result width in bits.
REQ-002 Parameter TMO, default 64: maximum cycles from GO to VALID before timeout.
REQ-003 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port RST, input, 1: reset, asynchronous, active-high.
REQ-005 Port START, input, 1: level; a burst starts on the first cycle it is sampled high while in IDLE.
REQ-006 Port CONT, input, 1: continuous mode; a new burst starts after each DONE while CONT is high.
REQ-007 Port NAVG, input, 2: burst length is 2^NAVG samples (1, 2, 4 or 8).
REQ-008 Port CLR, input, 1: clears the ERR flag.
REQ-009 Port GO, output, 1: conversion request to the SARADC.
REQ-010 Port VALID, input, 1: SARADC result strobe, one cycle wide.
REQ-011 Port RESULT, input, W: SARADC conversion result.
REQ-012 Port AVG, output, W: mean of the last completed burst.
REQ-013 Port MINV, output, W: minimum sample of the last completed burst.
REQ-014 Port MAXV, output, W: maximum sample of the last completed burst.
REQ-015 Port DONE, output, 1: one-cycle pulse when AVG, MINV and MAXV update.
REQ-016 Port BUSY, output, 1: high in every state except IDLE.
REQ-017 Port ERR, output, 1: sticky timeout flag.

Function
REQ-018 The FSM SHALL have four states, IDLE, REQ, WAIT and FIN, and the only transitions are these:
- IDLE→REQ on START.
- REQ→WAIT after exactly one cycle.
- WAIT→REQ on VALID when more samples remain in the burst.
- WAIT→FIN on VALID for the last sample.
- WAIT→IDLE on timeout.
- FIN→REQ if CONT is high; FIN→IDLE otherwise.
REQ-019 GO SHALL be high only in REQ, as a one-cycle pulse per sample.
REQ-020 On entering REQ from IDLE or FIN, NAVG SHALL be latched, and the sample counter, accumulator, running minimum (all-ones) and running maximum (zero) SHALL be reset.
REQ-021 In WAIT, when VALID is high, RESULT SHALL be added into an accumulator W+3 bits wide (no overflow possible) and compared into the running minimum and maximum in the same edge.
REQ-022 VALID SHALL be ignored in IDLE, REQ and FIN.
REQ-023 In FIN, AVG SHALL be loaded with the accumulator right-shifted by the latched NAVG (truncating), MINV and MAXV SHALL be loaded from the running values, and DONE SHALL be high for that single cycle.
REQ-024 Latency from the VALID of the last sample to DONE SHALL be exactly one cycle.
REQ-025 A wait counter SHALL count cycles in WAIT; if it reaches TMO-1 without VALID, ERR SHALL be set, the burst SHALL be aborted, and AVG, MINV and MAXV SHALL keep their previous values.
REQ-026 ERR SHALL clear on CLR; if CLR and a timeout occur in the same cycle, the timeout wins and ERR stays set.
REQ-027 START SHALL be ignored while BUSY is high.
REQ-028 CONT going low mid-burst SHALL let the current burst finish, after which the block returns to IDLE.
REQ-029 NAVG changes SHALL have no effect until the next burst start.

Reset
REQ-030 While RST is high, the block SHALL be in IDLE with GO, DONE, BUSY and ERR at 0 and AVG, MINV, MAXV, the accumulator and all counters at 0.
REQ-031 RST asserted mid-burst SHALL abort the burst immediately, drop GO asynchronously, and discard the partial statistics.

Structure
REQ-032 A shared package adc_seq_pkg SHALL hold the state enum, W_DEF=5, ACC_W=W+3 and TMO_DEF=64.
REQ-033 The accumulate/min/max datapath SHALL be a single sub-module, adc_seq_stats, with inputs clr, en and din and outputs sum, mn and mx.
REQ-034 The FSM, sample counter and wait counter SHALL reside in adc_seq.

Verification
REQ-035 NAVG=2, START pulse, VALID returning RESULT 3, 7, 10, 12 → four GO pulses, DONE one cycle after the fourth VALID, AVG=8, MINV=3, MAXV=12.
REQ-036 NAVG=3, all eight samples 31 → AVG=31, MINV=MAXV=31, with no accumulator overflow.
REQ-037 NAVG=0, VALID withheld for 64 cycles → ERR=1, BUSY=0, AVG/MINV/MAXV unchanged; then CLR pulse → ERR=0.
REQ-038 CONT=1, NAVG=1, samples 4, 6 then 1, 1 → DONE twice, AVG=5 then 1, REQ entered the cycle after the first DONE; CONT dropped during the second burst → IDLE after the second DONE.
REQ-039 RST asserted in WAIT after two of four samples → outputs zero immediately; a subsequent burst of 2, 2, 2, 2 → AVG=2.
REQ-040 VALID pulsed in IDLE, and START pulsed while BUSY → no state change and no extra GO.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC burst sequencer.
package adc_seq_pkg;

    localparam int W_DEF   = 5;
    localparam int ACC_W   = W_DEF + 3;
    localparam int TMO_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Index of the final sample in a burst of 2^navg samples.
    function automatic logic [2:0] last_idx(input logic [1:0] navg);
        case (navg)
            2'd0:    last_idx = 3'd0;
            2'd1:    last_idx = 3'd1;
            2'd2:    last_idx = 3'd3;
            default: last_idx = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/adc_seq_stats.sv
// Running sum, minimum and maximum over the samples of one burst.
module adc_seq_stats
    import adc_seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W+2:0] sum,
    output logic [W-1:0] mn,
    output logic [W-1:0] mx
);

    // Accumulate and track extremes; clr restarts the burst statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            mn  <= '0;
            mx  <= '0;
        end else if (clr) begin
            sum <= '0;
            mn  <= '1;
            mx  <= '0;
        end else if (en) begin
            sum <= sum + {3'b000, din};
            mn  <= (din < mn) ? din : mn;
            mx  <= (din > mx) ? din : mx;
        end else begin
            sum <= sum;
            mn  <= mn;
            mx  <= mx;
        end
    end

endmodule

// File: rtl/adc_seq.sv
// Burst sequencer for a SAR ADC: requests 2^NAVG conversions and reports
// mean, minimum and maximum, with a per-sample timeout.
module adc_seq
    import adc_seq_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int TMO = TMO_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic         CONT,
    input  logic [1:0]   NAVG,
    input  logic         CLR,
    output logic         GO,
    input  logic         VALID,
    input  logic [W-1:0] RESULT,
    output logic [W-1:0] AVG,
    output logic [W-1:0] MINV,
    output logic [W-1:0] MAXV,
    output logic         DONE,
    output logic         BUSY,
    output logic         ERR
);

    localparam int AW = W + 3;
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      navg_r;
    logic [2:0]      scnt;
    logic [TW-1:0]   wcnt;
    logic            start_burst;
    logic            take;
    logic            tmo;
    logic [AW-1:0]   sum;
    logic [W-1:0]    mn;
    logic [W-1:0]    mx;

    adc_seq_stats #(.W(W)) u_stats (
        .clk (CLK),
        .rst (RST),
        .clr (start_burst),
        .en  (take),
        .din (RESULT),
        .sum (sum),
        .mn  (mn),
        .mx  (mx)
    );

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; VALID only matters while waiting for a conversion.
    always_comb begin
        state_nxt   = state;
        start_burst = 1'b0;
        take        = 1'b0;
        tmo         = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt   = REQ;
                    start_burst = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            REQ: state_nxt = WAIT;
            WAIT: begin
                if (VALID) begin
                    take = 1'b1;
                    if (scnt == last_idx(navg_r)) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = REQ;
                    end
                end else if (wcnt == TW'(TMO - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            FIN: begin
                if (CONT) begin
                    state_nxt   = REQ;
                    start_burst = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, registered strobes, result registers and the sticky error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            navg_r <= 2'd0;
            scnt   <= 3'd0;
            wcnt   <= '0;
            GO     <= 1'b0;
            DONE   <= 1'b0;
            BUSY   <= 1'b0;
            ERR    <= 1'b0;
            AVG    <= '0;
            MINV   <= '0;
            MAXV   <= '0;
        end else begin
            GO   <= (state_nxt == REQ);
            DONE <= (state_nxt == FIN);
            BUSY <= (state_nxt != IDLE);
            if (start_burst) begin
                navg_r <= NAVG;
                scnt   <= 3'd0;
            end else if (take) begin
                scnt <= scnt + 3'd1;
            end else begin
                scnt <= scnt;
            end
            if ((state == WAIT) && !VALID && !tmo) begin
                wcnt <= wcnt + TW'(1);
            end else begin
                wcnt <= '0;
            end
            // Results move only on a completed burst; an aborted one leaves them.
            if (state == FIN) begin
                AVG  <= W'(sum >> navg_r);
                MINV <= mn;
                MAXV <= mx;
            end else begin
                AVG  <= AVG;
                MINV <= MINV;
                MAXV <= MAXV;
            end
            if (tmo) begin
                ERR <= 1'b1;
            end else if (CLR) begin
                ERR <= 1'b0;
            end else begin
                ERR <= ERR;
            end
        end
    end

endmodule

// File: tb/tb_adc_seq.sv
// Scoreboard bench for adc_seq: an ADC responder feeds queued samples, a
// monitor checks every DONE against burst statistics computed arithmetically.
module tb_adc_seq;

    localparam int W = 5;

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic         CONT;
    logic [1:0]   NAVG;
    logic         CLR;
    logic         GO;
    logic         VALID;
    logic [W-1:0] RESULT;
    logic [W-1:0] AVG;
    logic [W-1:0] MINV;
    logic [W-1:0] MAXV;
    logic         DONE;
    logic         BUSY;
    logic         ERR;

    typedef struct {
        int avg;
        int mn;
        int mx;
        bit nreq;
    } exp_t;

    exp_t exp_q[$];
    int   samp_q[$];
    int   fx[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   vld_cyc = -10;
    int   gocnt = 0;
    int   dones = 0;
    int   fdly = 0;
    int   pend = 0;
    int   cur = 0;
    int   lavg = 0;
    int   lmin = 0;
    int   lmax = 0;
    bit   withhold = 1'b0;
    bit   stray = 1'b0;

    adc_seq dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .CONT   (CONT),
        .NAVG   (NAVG),
        .CLR    (CLR),
        .GO     (GO),
        .VALID  (VALID),
        .RESULT (RESULT),
        .AVG    (AVG),
        .MINV   (MINV),
        .MAXV   (MAXV),
        .DONE   (DONE),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: burst of fx[0..2^na-1] gives floor mean, min and max.
    task automatic add_burst(input int na, input bit rnd, input bit nreq);
        int   n;
        int   s;
        exp_t e;
        n = 1 << na;
        if (rnd) begin
            fx.delete();
            for (int i = 0; i < n; i++) fx.push_back($urandom_range(0, 31));
        end
        s = 0;
        e.mn = 31;
        e.mx = 0;
        for (int i = 0; i < n; i++) begin
            samp_q.push_back(fx[i]);
            s += fx[i];
            if (fx[i] < e.mn) e.mn = fx[i];
            if (fx[i] > e.mx) e.mx = fx[i];
        end
        e.avg = s / n;
        e.nreq = nreq;
        exp_q.push_back(e);
        lavg = e.avg;
        lmin = e.mn;
        lmax = e.mx;
    endtask

    task automatic kick(input int na, input bit scramble);
        @(negedge CLK);
        NAVG = 2'(na);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        if (scramble) NAVG = 2'($urandom);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_within_budget", int'(n < 400), 1);
        repeat (2) @(negedge CLK);
    endtask

    // SARADC model: answer each GO with the next queued sample after a delay.
    initial begin : adc
        VALID = 1'b0;
        RESULT = '0;
        forever begin
            @(negedge CLK);
            VALID = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    VALID = 1'b1;
                    RESULT = W'(cur);
                    vld_cyc = cyc;
                end
            end else if (stray) begin
                stray = 1'b0;
                VALID = 1'b1;
                RESULT = W'($urandom);
            end
            if (GO) begin
                gocnt++;
                if (!withhold) begin
                    checks++;
                    if (samp_q.size() == 0) begin
                        errors++;
                        $display("FAIL go_without_sample: got GO, expected no request");
                    end else begin
                        cur = samp_q.pop_front();
                        pend = (fdly > 0) ? fdly : $urandom_range(1, 4);
                    end
                end
            end
        end
    end

    // Monitor: every DONE pops one expected burst result.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge CLK);
            if (DONE) begin
                dones++;
                chk("done_latency", cyc - vld_cyc, 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got DONE, expected none");
                end else begin
                    e = exp_q.pop_front();
                    @(negedge CLK);
                    chk("avg", int'(AVG), e.avg);
                    chk("minv", int'(MINV), e.mn);
                    chk("maxv", int'(MAXV), e.mx);
                    chk("done_one_cycle", int'(DONE), 0);
                    if (e.nreq) chk("fin_to_req_go", int'(GO), 1);
                    else        chk("fin_to_idle_busy", int'(BUSY), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int g;
        int d;
        int n;
        RST = 1'b1;
        START = 1'b0;
        CONT = 1'b0;
        CLR = 1'b0;
        NAVG = 2'd0;
        repeat (3) @(negedge CLK);
        chk("rst_go", int'(GO), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_avg", int'(AVG), 0);
        chk("rst_minmax", int'(MINV) + int'(MAXV), 0);
        RST = 1'b0;
        @(negedge CLK);

        g = gocnt;
        fx = '{3, 7, 10, 12};
        add_burst(2, 1'b0, 1'b0);
        kick(2, 1'b1);
        wait_idle();
        chk("four_go_pulses", gocnt - g, 4);
        chk("avg_3_7_10_12", int'(AVG), 8);

        fx = '{31, 31, 31, 31, 31, 31, 31, 31};
        add_burst(3, 1'b0, 1'b0);
        kick(3, 1'b1);
        wait_idle();
        chk("avg_all_31", int'(AVG), 31);

        for (int k = 0; k < 14; k++) begin
            n = $urandom_range(0, 3);
            add_burst(n, 1'b1, 1'b0);
            kick(n, 1'b1);
            wait_idle();
        end

        // Continuous mode: second burst follows FIN directly, CONT drops mid-burst.
        d = dones;
        CONT = 1'b1;
        fx = '{4, 6};
        add_burst(1, 1'b0, 1'b1);
        fx = '{1, 1};
        add_burst(1, 1'b0, 1'b0);
        kick(1, 1'b0);
        n = 0;
        while (dones < d + 1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        CONT = 1'b0;
        wait_idle();
        chk("cont_two_dones", dones - d, 2);
        chk("cont_second_avg", int'(AVG), 1);

        // Timeout: VALID withheld; ERR must rise after exactly TMO wait cycles.
        withhold = 1'b1;
        @(negedge CLK);
        NAVG = 2'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("tmo_go", int'(GO), 1);
        repeat (64) @(negedge CLK);
        chk("tmo_err_not_yet", int'(ERR), 0);
        chk("tmo_still_busy", int'(BUSY), 1);
        @(negedge CLK);
        chk("tmo_err_set", int'(ERR), 1);
        chk("tmo_busy_low", int'(BUSY), 0);
        chk("tmo_avg_kept", int'(AVG), lavg);
        chk("tmo_min_kept", int'(MINV), lmin);
        chk("tmo_max_kept", int'(MAXV), lmax);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_err", int'(ERR), 0);

        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("tmo2_go", int'(GO), 1);
        repeat (63) @(negedge CLK);
        CLR = 1'b1;
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        chk("tmo_beats_clr", int'(ERR), 1);
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_err_again", int'(ERR), 0);
        withhold = 1'b0;

        // Stray VALID in IDLE must not start anything.
        g = gocnt;
        d = dones;
        stray = 1'b1;
        repeat (4) @(negedge CLK);
        chk("stray_valid_busy", int'(BUSY), 0);
        chk("stray_valid_no_go", gocnt - g, 0);
        chk("stray_valid_no_done", dones - d, 0);

        // Reset in WAIT after two of four samples.
        fdly = 6;
        g = gocnt;
        fx = '{9, 1, 20, 5};
        add_burst(2, 1'b0, 1'b0);
        kick(2, 1'b0);
        n = 0;
        while (gocnt < g + 3 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("midrst_go", int'(GO), 0);
        chk("midrst_busy", int'(BUSY), 0);
        chk("midrst_done", int'(DONE), 0);
        chk("midrst_avg", int'(AVG), 0);
        chk("midrst_minmax", int'(MINV) + int'(MAXV), 0);
        exp_q.delete();
        samp_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        fdly = 0;
        chk("post_rst_idle", int'(BUSY), 0);
        fx = '{2, 2, 2, 2};
        add_burst(2, 1'b0, 1'b0);
        kick(2, 1'b1);
        wait_idle();
        chk("post_rst_avg", int'(AVG), 2);

        chk("samples_consumed", samp_q.size(), 0);
        chk("results_consumed", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
